ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
- Iterative RV32M multiply/divide sequencer attached beside the execute-stage ALU.
- Accepts an M-extension op once its forwarded operands are in EX, and stalls the pipeline while iterating.
- Presents the 32-bit result for one cycle so the instruction can advance to MEM with it.
- Shares the EX forwarding outputs (srcA / pre-ALUSrc B); the hazard unit ORs stallE into its stall/flush logic.

Parameters:
- XLEN, 32, operand/result width.
- ITERS, 32, shift/subtract iterations per op; must equal XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- mdValidE  in  1  EX holds an M-ext instruction.
- funct3E  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcAE  in  XLEN  forwarded rs1.
- srcBE  in  XLEN  forwarded rs2 (pre-ALUSrc).
- flushE  in  1  kill the EX instruction (branch taken / trap).
- stallE  out  1  hold IF/ID/EX; bubble into MEM.
- mdDoneE  out  1  result valid this cycle.
- mdResultE  out  XLEN  result; select over aluResultE when mdDoneE=1.

Behaviour:
- States: IDLE, RUN, DONE. Reset: state=IDLE, counter=0, accumulators=0, stallE=0, mdDoneE=0, mdResultE=0.
- IDLE
  - If mdValidE & ~flushE: latch funct3, operand magnitudes and result-sign flags, then go to RUN.
  - stallE is combinationally 1 in this cycle.
- RUN
  - One iteration per cycle, counter ITERS-1 down to 0; stallE=1.
  - On the count==0 cycle go to DONE.
- DONE
  - mdDoneE=1, stallE=0, mdResultE registered and stable; go to IDLE unconditionally.
  - mdValidE still high in DONE (same instruction) must NOT restart.
- Latency: start cycle + 32 RUN cycles gives 33 stall cycles, then 1 DONE cycle. Back-to-back M-ops may start in the IDLE cycle after DONE.
- Multiply
  - Shift-add on |A|,|B| into a 64-bit product, negated when the sign flag is set.
  - Signedness: MULH s×s, MULHSU s×u, MULHU u×u.
  - MUL returns the low 32 bits; the H variants return the high 32 bits.
- Divide
  - Restoring division on magnitudes.
  - Quotient sign = signA^signB. Remainder sign = signA.
- Boundary cases:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend. Still runs the full 33 cycles.
  - Signed overflow, 0x80000000 / -1: DIV gives 0x80000000, REM gives 0.
- flushE in RUN or IDLE-start: go to IDLE next cycle, no mdDoneE, stallE drops the next cycle. flushE in DONE is ignored; the MEM bubble is handled downstream.
- rst mid-operation: immediate return to reset values on the next edge.
- mdValidE dropping during RUN without flushE is illegal; covered by an assertion.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, if srcBE==0, or srcAE==0 for a multiply, skip RUN and go straight to DONE. Result is computed per the rules above; stall = 1 cycle, total 2 cycles.
- Undefined: every op takes the full fixed latency.
- Results are identical either way.

Decomposition:
- Shared package muldiv_pkg holds:
  - md_op_e enum for the 8 funct3 codes.
  - md_state_e {IDLE, RUN, DONE}.
  - Constants MD_DIV0_Q = 32'hFFFF_FFFF and MD_INT_MIN = 32'h8000_0000.
- One sub-module, muldiv_datapath: accumulators, shift/subtract step, sign fix-up. ex_muldiv_ctrl keeps the FSM, counter and stall/handshake.

Test Plan:
- MUL 7 × -3 → after 33 stall cycles mdDoneE=1, mdResultE=0xFFFFFFEB; stallE low in the DONE cycle only.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5 (2 cycles with MULDIV_EARLY_OUT_EN); DIV 0x80000000 / -1 → 0x80000000, REM → 0.
- Start DIVU, assert flushE at RUN cycle 10 → IDLE next cycle, no mdDoneE, stallE=0. Assert rst at RUN cycle 20 → all outputs 0.
- Two back-to-back MULs with mdValidE held → exactly two DONE pulses 34 cycles apart; no restart inside DONE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
//   md_op_e    : funct3 encodings of the eight M-extension ops
//   md_state_e : sequencer states
//   MD_DIV0_Q  : quotient returned for a divide by zero
//   MD_INT_MIN : most negative 32-bit value (signed-overflow dividend)
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [31:0] MD_DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

  // rs1 is signed for every op except MULHU, DIVU, REMU.
  function automatic logic op_signed_a(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is additionally unsigned for MULHSU.
  function automatic logic op_signed_b(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage handshake between the pipeline and the multiply/divide sequencer.
//   master : pipeline side, drives the op, forwarded operands and flush
//   slave  : sequencer side, returns stall, done strobe and result
interface ex_muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mdValidE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] srcAE;
  logic [XLEN-1:0] srcBE;
  logic            flushE;
  logic            stallE;
  logic            mdDoneE;
  logic [XLEN-1:0] mdResultE;

  modport master (
    output mdValidE, funct3E, srcAE, srcBE, flushE,
    input  stallE, mdDoneE, mdResultE
  );

  modport slave (
    input  mdValidE, funct3E, srcAE, srcBE, flushE,
    output stallE, mdDoneE, mdResultE
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Datapath for the iterative multiplier/divider: operand magnitudes,
// shared hi/lo accumulator, one shift-add or restoring-subtract step per
// cycle, and the final sign fix-up into a registered result.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : latch op, magnitudes and sign flags from src_a/src_b
//   step          : perform one iteration
//   finish        : register the result computed from this cycle's step
//   early         : register the result straight from the operands
//   op_in         : operation being started
//   src_a, src_b  : forwarded rs1 / rs2
//   result        : registered result
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            finish,
  input  logic            early,
  input  md_op_e          op_in,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result
);

  logic            sign_a_in, sign_b_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  md_op_e          op_q;
  logic            neg_q, sign_a_q, div0_q;
  logic [XLEN-1:0] addend_q, hi_q, lo_q, result_q;

  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ok;
  logic [XLEN-1:0] hi_nxt, lo_nxt;

  md_op_e            fin_op;
  logic              fin_neg, fin_sign_a, fin_div0;
  logic [XLEN-1:0]   fin_hi, fin_lo, fin_result;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sign_a_in = op_signed_a(op_in) & src_a[XLEN-1];
    sign_b_in = op_signed_b(op_in) & src_b[XLEN-1];
    a_mag_in  = sign_a_in ? -src_a : src_a;
    b_mag_in  = sign_b_in ? -src_b : src_b;
  end

  // Multiply: {hi,lo} starts as {0,multiplier}; add the multiplicand into hi
  // when lo[0] is set, then shift the whole pair right.
  // Divide: {hi,lo} starts as {0,dividend}; shift left into hi, subtract the
  // divisor if it fits, and shift the quotient bit into lo.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, addend_q};
    // A set top bit means the shifted remainder already exceeds any divisor.
    div_ok    = div_shift[XLEN] | ~div_diff[XLEN];
    if (op_is_div(op_q)) begin
      hi_nxt = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], div_ok};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up. On an early exit the operands are still on the inputs and
  // the magnitude result is trivial: product 0, or remainder = |dividend|.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  //       (defaults first, or a full if/else) so no latch is inferred.
  always_comb begin
    if (early) begin
      fin_op     = op_in;
      fin_neg    = sign_a_in ^ sign_b_in;
      fin_sign_a = sign_a_in;
      fin_div0   = (src_b == '0);
      fin_hi     = op_is_div(op_in) ? a_mag_in : '0;
      fin_lo     = '0;
    end else begin
      fin_op     = op_q;
      fin_neg    = neg_q;
      fin_sign_a = sign_a_q;
      fin_div0   = div0_q;
      fin_hi     = hi_nxt;
      fin_lo     = lo_nxt;
    end
    prod = fin_neg ? -{fin_hi, fin_lo} : {fin_hi, fin_lo};
    fin_result = '0;
    case (fin_op)
      MD_MUL:                       fin_result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin_result = prod[2*XLEN-1:XLEN];
      // Divide by zero overrides the sign rule; INT_MIN / -1 falls out of
      // the magnitude arithmetic as INT_MIN with remainder 0.
      MD_DIV, MD_DIVU: fin_result = fin_div0 ? MD_DIV0_Q : (fin_neg ? -fin_lo : fin_lo);
      MD_REM, MD_REMU: fin_result = fin_sign_a ? -fin_hi : fin_hi;
      default:         fin_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  //       samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      div0_q   <= 1'b0;
      addend_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      if (start) begin
        op_q     <= op_in;
        neg_q    <= sign_a_in ^ sign_b_in;
        sign_a_q <= sign_a_in;
        div0_q   <= (src_b == '0);
        addend_q <= op_is_div(op_in) ? b_mag_in : a_mag_in;
        hi_q     <= '0;
        lo_q     <= op_is_div(op_in) ? a_mag_in : b_mag_in;
      end else if (step) begin
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
      end
      if (finish || early) begin
        result_q <= fin_result;
      end
    end
  end

  assign result = result_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide sequencer beside the EX-stage ALU. Accepts an
// M-extension op, stalls IF/ID/EX while iterating, then presents the result
// for one cycle (mdDoneE) so the instruction can advance to MEM.
// Ports:
//   clk : clock
//   rst : synchronous reset, active-high
//   md  : ex_muldiv_ctrl_if.slave (mdValidE, funct3E, srcAE, srcBE, flushE
//         in; stallE, mdDoneE, mdResultE out)
// Build option: define MULDIV_EARLY_OUT_EN to skip iteration when rs2 is
// zero, or rs1 is zero for a multiply. Results are identical either way.
// ITERS must equal XLEN.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input logic               clk,
  input logic               rst,
  ex_muldiv_ctrl_if.slave   md
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT_EN = 1'b1;
`else
  localparam bit EARLY_OUT_EN = 1'b0;
`endif

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            start, step, finish, early, early_ok;
  logic            stall, done;
  md_op_e          op_in;
  logic [XLEN-1:0] result;

  assign op_in    = md_op_e'(md.funct3E);
  assign early_ok = EARLY_OUT_EN &&
                    ((md.srcBE == '0) || ((md.srcAE == '0) && !op_is_div(op_in)));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    start   = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    early   = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // Stall is combinational here so the instruction holds in EX on the
        // very cycle the op is accepted.
        if (md.mdValidE && !md.flushE) begin
          stall = 1'b1;
          start = 1'b1;
          if (early_ok) begin
            early   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
            count_d = CW'(ITERS - 1);
          end
        end
      end
      RUN: begin
        stall = 1'b1;
        if (md.flushE) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (count_q == '0) begin
            finish  = 1'b1;
            state_d = DONE;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      DONE: begin
        // Unconditional exit: mdValidE is still the same instruction here.
        // A flush in this cycle is the downstream MEM bubble's concern.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .step   (step),
    .finish (finish),
    .early  (early),
    .op_in  (op_in),
    .src_a  (md.srcAE),
    .src_b  (md.srcBE),
    .result (result)
  );

  assign md.stallE    = stall;
  assign md.mdDoneE   = done;
  assign md.mdResultE = result;

  // The instruction may only leave EX mid-iteration through a flush.
  a_valid_held_in_run: assert property (
    @(posedge clk) disable iff (rst) (state_q == RUN) |-> (md.mdValidE || md.flushE)
  );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl. Expected results are pushed to a
// scoreboard queue when an op is driven and popped when mdDoneE fires.
module tb_ex_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_muldiv_ctrl_if #(.XLEN(32)) md_if ();

  ex_muldiv_ctrl #(.XLEN(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  function automatic bit is_early(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return EARLY && ((b == 32'd0) || ((a == 32'd0) && !f3[2]));
  endfunction

  // Reference model built on native 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, ps;
    logic [63:0]        pu;
    logic signed [31:0] qa, qb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    qa = a;
    qb = b;
    case (f3)
      3'b000: begin ps = sa * sb; return ps[31:0]; end
      3'b001: begin ps = sa * sb; return ps[63:32]; end
      3'b010: begin ps = sa * ub; return ps[63:32]; end
      3'b011: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == MD_INT_MIN && b == 32'hFFFF_FFFF) return MD_INT_MIN;
        return qa / qb;
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == MD_INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
        return qa % qb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic idle_inputs();
    md_if.mdValidE = 1'b0;
    md_if.funct3E  = 3'b000;
    md_if.srcAE    = 32'd0;
    md_if.srcBE    = 32'd0;
    md_if.flushE   = 1'b0;
  endtask

  // Drive one op with mdValidE held until DONE, then check result, stall
  // count and that no restart follows.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int          stalls, cycles, exp_stalls;
    bit          seen;
    logic [31:0] want;
    exp_stalls = is_early(f3, a, b) ? 1 : 33;
    @(negedge clk);
    md_if.mdValidE = 1'b1;
    md_if.funct3E  = f3;
    md_if.srcAE    = a;
    md_if.srcBE    = b;
    exp_q.push_back(exp);
    stalls = 0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 100) begin
      #1;
      if (md_if.mdDoneE === 1'b1) begin
        seen = 1'b1;
        want = exp_q.pop_front();
        vectors++;
        if (md_if.mdResultE !== want) begin
          miscompares++;
          $display("FAIL %s result: got %h want %h", name, md_if.mdResultE, want);
        end
        vectors++;
        if (md_if.stallE !== 1'b0) begin
          miscompares++;
          $display("FAIL %s stall_in_done: got %b want 0", name, md_if.stallE);
        end
        vectors++;
        if (stalls != exp_stalls) begin
          miscompares++;
          $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stalls);
        end
      end else begin
        if (md_if.stallE === 1'b1) stalls++;
        cycles++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no mdDoneE after %0d cycles", name, cycles);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (md_if.stallE !== 1'b0 || md_if.mdDoneE !== 1'b0) begin
      miscompares++;
      $display("FAIL %s no_restart: stall %b done %b want 0 0", name, md_if.stallE, md_if.mdDoneE);
    end
  endtask

  task automatic watch_no_done(input int n, input string name);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (md_if.mdDoneE !== 1'b0) hits++;
    end
    vectors++;
    if (hits != 0) begin
      miscompares++;
      $display("FAIL %s spurious_done: got %0d pulses want 0", name, hits);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (md_if.stallE !== 1'b0 || md_if.mdDoneE !== 1'b0 || md_if.mdResultE !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: stall %b done %b result %h want 0 0 0",
               md_if.stallE, md_if.mdDoneE, md_if.mdResultE);
    end
    @(negedge clk);
    rst = 1'b0;
    watch_no_done(3, "post_reset");
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL_7_x_m3");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH_min_x_min");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU_max_x_max");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU_m1_x_max");
    run_op(3'b000, 32'd0,         32'd1234,      32'd0,         "MUL_zero_a");
    run_op(3'b011, 32'h1234_5678, 32'd0,         32'd0,         "MULHU_zero_b");
  endtask

  task automatic test_div();
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "DIV_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "REM_m7_2");
    run_op(3'b101, 32'd100,       32'd7,         32'd14,        "DIVU_100_7");
    run_op(3'b111, 32'd100,       32'd7,         32'd2,         "REMU_100_7");
    run_op(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         "REM_7_m2");
  endtask

  task automatic test_boundary();
    run_op(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, "DIV_5_0");
    run_op(3'b110, 32'd5,         32'd0,         32'd5,         "REM_5_0");
    run_op(3'b100, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFFF, "DIV_m10_0");
    run_op(3'b111, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, "REMU_x_0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "REM_ovf");
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(f3, a, b, model(f3, a, b), "random");
    end
  endtask

  task automatic test_back_to_back();
    int          dones = 0, cyc = 0, first_at = -1, second_at = -1, extra = 0;
    bit          switched = 1'b0;
    logic [31:0] want;
    @(negedge clk);
    md_if.mdValidE = 1'b1;
    md_if.funct3E  = 3'b000;
    md_if.srcAE    = 32'd3;
    md_if.srcBE    = 32'd4;
    exp_q.push_back(32'd12);
    while (dones < 2 && cyc < 120) begin
      #1;
      if (md_if.mdDoneE === 1'b1) begin
        dones++;
        if (dones == 1) first_at = cyc; else second_at = cyc;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        vectors++;
        if (md_if.mdResultE !== want) begin
          miscompares++;
          $display("FAIL b2b_result_%0d: got %h want %h", dones, md_if.mdResultE, want);
        end
      end
      @(negedge clk);
      cyc++;
      if (dones == 1 && !switched) begin
        // Next instruction arrives in EX right after DONE, mdValidE held.
        switched     = 1'b1;
        md_if.srcAE  = 32'hFFFF_FFFB;
        md_if.srcBE  = 32'd9;
        exp_q.push_back(32'hFFFF_FFD3);
      end
    end
    idle_inputs();
    for (int i = 0; i < 40; i++) begin
      #1;
      if (md_if.mdDoneE !== 1'b0) extra++;
      @(negedge clk);
    end
    vectors++;
    if (dones != 2 || extra != 0) begin
      miscompares++;
      $display("FAIL b2b_pulse_count: got %0d+%0d want 2+0", dones, extra);
    end
    vectors++;
    if (second_at - first_at != 34) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d want 34", second_at - first_at);
    end
    exp_q.delete();
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    md_if.mdValidE = 1'b1;
    md_if.funct3E  = 3'b000;
    md_if.srcAE    = 32'd5;
    md_if.srcBE    = 32'd6;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    vectors++;
    if (md_if.stallE !== 1'b0 || md_if.mdDoneE !== 1'b0 || md_if.mdResultE !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid: stall %b done %b result %h want 0 0 0",
               md_if.stallE, md_if.mdDoneE, md_if.mdResultE);
    end
    @(negedge clk);
    rst = 1'b0;
    watch_no_done(40, "rst_mid");
  endtask

  task automatic test_flush();
    @(negedge clk);
    md_if.mdValidE = 1'b1;
    md_if.funct3E  = 3'b101;
    md_if.srcAE    = 32'd1000;
    md_if.srcBE    = 32'd3;
    repeat (10) @(negedge clk);
    md_if.flushE = 1'b1;
    #1;
    vectors++;
    if (md_if.stallE !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_run_stall: got %b want 1", md_if.stallE);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (md_if.stallE !== 1'b0 || md_if.mdDoneE !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_run_after: stall %b done %b want 0 0", md_if.stallE, md_if.mdDoneE);
    end
    watch_no_done(40, "flush_run");

    @(negedge clk);
    md_if.mdValidE = 1'b1;
    md_if.flushE   = 1'b1;
    md_if.funct3E  = 3'b100;
    md_if.srcAE    = 32'd9;
    md_if.srcBE    = 32'd2;
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (md_if.stallE !== 1'b0 || md_if.mdDoneE !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start_after: stall %b done %b want 0 0", md_if.stallE, md_if.mdDoneE);
    end
    watch_no_done(40, "flush_start");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_boundary();
    test_random();
    test_back_to_back();
    test_rst_mid();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
